// File: rtl/pal_pkg.sv
// Shared types and constants for the palindrome-check arbiter.
package pal_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        RESP  = 2'd2
    } pal_arb_state_t;

    localparam int PAL_STAT_W = 16;

    // Saturating increment for the statistics counters
    function automatic logic [PAL_STAT_W-1:0] sat_inc(input logic [PAL_STAT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/pal_word_check.sv
// Combinational palindrome evaluator: mirrored bit pairs must match; for odd W the middle bit is ignored.
module pal_word_check #(
    parameter int W = 4
) (
    input  logic [W-1:0] word,
    output logic         pal
);

    localparam int HALF = W / 2;

    logic [HALF-1:0] pair_eq;

    genvar gi;
    generate
        for (gi = 0; gi < HALF; gi++) begin : g_pair
            assign pair_eq[gi] = (word[gi] == word[W-1-gi]);
        end
    endgenerate

    assign pal = &pair_eq;

endmodule

// File: rtl/pal_check_arbiter.sv
// Round-robin front end sharing one palindrome checker among N_REQ requesters.
// Optional statistics counters are enabled by defining PAL_ARB_STATS_EN.
module pal_check_arbiter
    import pal_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int W     = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ*W-1:0] req_data,
    output logic [N_REQ-1:0]   req_ready,
    output logic               rsp_valid,
    output logic [ID_W-1:0]    rsp_id,
    output logic               rsp_pal,
    input  logic               rsp_ready
`ifdef PAL_ARB_STATS_EN
    ,
    output logic [PAL_STAT_W-1:0] stat_checks,
    output logic [PAL_STAT_W-1:0] stat_hits
`endif
);

    pal_arb_state_t state_reg, state_next;

    logic [W-1:0]    word_reg;
    logic [ID_W-1:0] id_reg;
    logic [ID_W-1:0] rr_ptr_reg;
    logic            rsp_valid_reg;
    logic [ID_W-1:0] rsp_id_reg;
    logic            rsp_pal_reg;

    logic [W-1:0]    data_arr [N_REQ];
    logic            grant_found;
    logic [ID_W-1:0] grant_id;
    logic [ID_W-1:0] search_id;
    logic            accept;
    logic            word_pal;
    logic            rsp_done;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_req
            assign data_arr[gi]  = req_data[gi*W +: W];
            assign req_ready[gi] = (state_reg == IDLE) && grant_found && (grant_id == ID_W'(gi));
        end
    endgenerate

    // Scan offsets from highest to lowest so the closest valid requester to rr_ptr wins.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        search_id   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            search_id = ID_W'((int'(rr_ptr_reg) + k) % N_REQ);
            if (req_valid[search_id]) begin
                grant_found = 1'b1;
                grant_id    = search_id;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        rsp_done   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (grant_found) begin
                    accept     = 1'b1;
                    state_next = CHECK;
                end
            end
            CHECK: state_next = RESP;
            RESP: begin
                if (rsp_ready) begin
                    rsp_done   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    pal_word_check #(.W(W)) u_word_check (
        .word (word_reg),
        .pal  (word_pal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_reg      <= '0;
            id_reg        <= '0;
            rr_ptr_reg    <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_id_reg    <= '0;
            rsp_pal_reg   <= 1'b0;
        end else begin
            if (accept) begin
                word_reg   <= data_arr[grant_id];
                id_reg     <= grant_id;
                rr_ptr_reg <= (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
            end
            if (state_reg == CHECK) begin
                rsp_pal_reg   <= word_pal;
                rsp_id_reg    <= id_reg;
                rsp_valid_reg <= 1'b1;
            end
            if (rsp_done) begin
                rsp_valid_reg <= 1'b0;
            end
        end
    end

    assign rsp_valid = rsp_valid_reg;
    assign rsp_id    = rsp_id_reg;
    assign rsp_pal   = rsp_pal_reg;

`ifdef PAL_ARB_STATS_EN
    logic [PAL_STAT_W-1:0] stat_checks_reg;
    logic [PAL_STAT_W-1:0] stat_hits_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_checks_reg <= '0;
            stat_hits_reg   <= '0;
        end else if (rsp_done) begin
            stat_checks_reg <= sat_inc(stat_checks_reg);
            if (rsp_pal_reg) begin
                stat_hits_reg <= sat_inc(stat_hits_reg);
            end
        end
    end

    assign stat_checks = stat_checks_reg;
    assign stat_hits   = stat_hits_reg;
`else
    // Statistics counters are absent in this build.
`endif

endmodule

// File: tb/tb_pal_check_arbiter.sv
// Directed self-checking bench for pal_check_arbiter (4x4-bit instance plus a 2x5-bit odd-width instance).
module tb_pal_check_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [15:0] req_data;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic        rsp_pal;
    logic        rsp_ready;
`ifdef PAL_ARB_STATS_EN
    logic [15:0] stat_checks;
    logic [15:0] stat_hits;
    logic [15:0] stat_checks5;
    logic [15:0] stat_hits5;
`endif

    logic [1:0]  v5;
    logic [9:0]  d5;
    logic [1:0]  r5;
    logic        rv5;
    logic [0:0]  id5;
    logic        pal5;
    logic        rr5;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pal_check_arbiter #(.N_REQ(4), .W(4)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_id      (rsp_id),
        .rsp_pal     (rsp_pal),
        .rsp_ready   (rsp_ready)
`ifdef PAL_ARB_STATS_EN
        ,
        .stat_checks (stat_checks),
        .stat_hits   (stat_hits)
`endif
    );

    pal_check_arbiter #(.N_REQ(2), .W(5)) u_dut5 (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (v5),
        .req_data    (d5),
        .req_ready   (r5),
        .rsp_valid   (rv5),
        .rsp_id      (id5),
        .rsp_pal     (pal5),
        .rsp_ready   (rr5)
`ifdef PAL_ARB_STATS_EN
        ,
        .stat_checks (stat_checks5),
        .stat_hits   (stat_hits5)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge (DUT in CHECK).
    task automatic issue(input int i, input logic [3:0] d);
        int n;
        req_data[i*4 +: 4] = d;
        req_valid[i]       = 1'b1;
        #1;
        n = 0;
        while (!req_ready[i] && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("grant_seen", 32'(req_ready[i]), 1);
        @(negedge clk);
        req_valid[i] = 1'b0;
    endtask

    // Waits (bounded) for a response with rsp_ready high; returns at a negedge back in IDLE.
    task automatic wait_rsp(input int exp_id, input int exp_pal);
        int n;
        n = 0;
        while (!rsp_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("rsp_valid_seen", 32'(rsp_valid), 1);
        check("rsp_id", 32'(rsp_id), 32'(exp_id));
        check("rsp_pal", 32'(rsp_pal), 32'(exp_pal));
        $display("rsp id=%0d pal=%0d", rsp_id, rsp_pal);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_pal;
        int e;

        rst_n = 1'b0; req_valid = '0; req_data = '0; rsp_ready = 1'b0;
        v5 = '0; d5 = '0; rr5 = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_rsp_valid", 32'(rsp_valid), 0);
        check("reset_rsp_id", 32'(rsp_id), 0);
        check("reset_rsp_pal", 32'(rsp_pal), 0);
        check("reset_req_ready", 32'(req_ready), 0);
        check("reset_rsp_valid5", 32'(rv5), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single palindrome from requester 2
        @(negedge clk);
        rsp_ready = 1'b1;
        req_data[11:8] = 4'b1001;
        req_valid[2]   = 1'b1;
        #1;
        check("t1_req_ready", 32'(req_ready), 'h4);
        @(negedge clk);
        req_valid = '0;
        check("t1_check_busy", 32'(req_ready), 0);
        check("t1_no_rsp_yet", 32'(rsp_valid), 0);
        @(negedge clk);
        check("t1_rsp_valid", 32'(rsp_valid), 1);
        check("t1_rsp_id", 32'(rsp_id), 2);
        check("t1_rsp_pal", 32'(rsp_pal), 1);
        $display("rsp id=%0d pal=%0d", rsp_id, rsp_pal);
        @(negedge clk);
        check("t1_rsp_drop", 32'(rsp_valid), 0);

        // Non-palindrome then palindrome from requester 0
        issue(0, 4'b0101);
        wait_rsp(0, 0);
        issue(0, 4'b0110);
        wait_rsp(0, 1);

        // Reset so round-robin starts at requester 0
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Fairness: all requesters valid, grants 0,1,2,3,0,1 every 3 cycles
        req_data  = {4'b1000, 4'b1111, 4'b0011, 4'b1001};
        exp_pal   = 4'b0101;
        req_valid = 4'hF;
        #1;
        check("rr_first", 32'(req_ready), 'h1);
        for (int k = 0; k < 6; k++) begin
            e = k % 4;
            @(negedge clk);
            check("rr_check_busy", 32'(req_ready), 0);
            @(negedge clk);
            check("rr_rsp_valid", 32'(rsp_valid), 1);
            check("rr_rsp_id", 32'(rsp_id), 32'(e));
            check("rr_rsp_pal", 32'(rsp_pal), 32'(exp_pal[e]));
            $display("rsp id=%0d pal=%0d", rsp_id, rsp_pal);
            @(negedge clk);
            check("rr_next_grant", 32'(req_ready), 32'(1 << ((k + 1) % 4)));
        end
        req_valid = '0;
        @(negedge clk);

        // Backpressure: requester 3 granted (pointer at 2), requester 1 waits
        rsp_ready = 1'b0;
        req_data[7:4] = 4'b1010;
        req_valid[1]  = 1'b1;
        issue(3, 4'b0110);
        check("bp_check_busy", 32'(req_ready), 0);
        @(negedge clk);
        for (int j = 0; j < 5; j++) begin
            check("bp_rsp_valid", 32'(rsp_valid), 1);
            check("bp_rsp_id", 32'(rsp_id), 3);
            check("bp_rsp_pal", 32'(rsp_pal), 1);
            check("bp_req_ready", 32'(req_ready), 0);
            @(negedge clk);
        end
        $display("rsp id=%0d pal=%0d", rsp_id, rsp_pal);
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_released", 32'(rsp_valid), 0);
        check("bp_waiting_grant", 32'(req_ready), 'h2);
        @(negedge clk);
        req_valid[1] = 1'b0;
        wait_rsp(1, 0);

        // Reset during CHECK; pointer returns to 0 so requester 2 beats 3
        issue(2, 4'b0000);
        rst_n = 1'b0;
        #1;
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_id", 32'(rsp_id), 0);
        check("rst_rsp_pal", 32'(rsp_pal), 0);
        check("rst_req_ready", 32'(req_ready), 0);
        req_data[15:12] = 4'b0110;
        req_valid = 4'b1100;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_regrant", 32'(req_ready), 'h4);
        @(negedge clk);
        req_valid = '0;
        wait_rsp(2, 1);

`ifdef PAL_ARB_STATS_EN
        check("stat_checks", 32'(stat_checks), 1);
        check("stat_hits", 32'(stat_hits), 1);
        force u_dut.stat_checks_reg = 16'hFFFF;
        @(negedge clk);
        release u_dut.stat_checks_reg;
        issue(0, 4'b1001);
        wait_rsp(0, 1);
        check("stat_checks_sat", 32'(stat_checks), 'hFFFF);
        check("stat_hits_2", 32'(stat_hits), 2);
`endif

        // Odd width: middle bit ignored
        rr5 = 1'b1;
        d5[4:0] = 5'b10101;
        v5 = 2'b01;
        #1;
        check("w5_ready0", 32'(r5), 'h1);
        @(negedge clk);
        v5 = '0;
        @(negedge clk);
        check("w5_rsp_valid", 32'(rv5), 1);
        check("w5_rsp_id", 32'(id5), 0);
        check("w5_pal_10101", 32'(pal5), 1);
        $display("rsp5 id=%0d pal=%0d", id5, pal5);
        @(negedge clk);
        d5[9:5] = 5'b10100;
        v5 = 2'b10;
        #1;
        check("w5_ready1", 32'(r5), 'h2);
        @(negedge clk);
        v5 = '0;
        @(negedge clk);
        check("w5_rsp_id1", 32'(id5), 1);
        check("w5_pal_10100", 32'(pal5), 0);
        $display("rsp5 id=%0d pal=%0d", id5, pal5);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
